cc_gateand_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered bitwise-AND unit between NUM_REQ requesters.
- Each requester presents an operand pair and a request.
- The arbiter grants one requester, latches its operands, computes A & B, and returns the result with the requester ID and a one-cycle acknowledge.
- Sits between the requesting blocks and the shared AND datapath.
- Fixed cost: one operation per 3 clock cycles.

---
 rtl/cc_gateand_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cc_gateand_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_gateand_arbiter.sv
// ---------------------------------------------------------------------------
// cc_gateand_arbiter
//   Round-robin arbiter and sequencer in front of a single registered
//   bitwise-AND unit shared by NUM_REQ = 2**ID_W requesters. One operation
//   takes exactly three cycles: IDLE (arbitrate + latch operands), BUSY
//   (compute, pulse Valid/Ack), DONE (clear, advance pointer).
//
//   Optional feature: define CC_GATEANDARBITER_STATS_EN to add a 16-bit
//   wrapping count of completed operations on CC_GateANDArbiter_OpCount_Out.
//
// Ports:
//   CC_GateANDArbiter_CLOCK_50     in   system clock (rising edge)
//   CC_GateANDArbiter_RESET_InLow  in   asynchronous active-low reset
//   CC_GateANDArbiter_Req_In       in   level requests, bit i = requester i
//   CC_GateANDArbiter_A_In         in   operand A, requester i at [i*DATA_W +: DATA_W]
//   CC_GateANDArbiter_B_In         in   operand B, same packing
//   CC_GateANDArbiter_Grant_Out    out  one-hot grant, high while in flight
//   CC_GateANDArbiter_Ack_Out      out  one-hot one-cycle completion pulse
//   CC_GateANDArbiter_Valid_Out    out  one-cycle result-valid pulse
//   CC_GateANDArbiter_Id_Out       out  requester index of Result_Out
//   CC_GateANDArbiter_Result_Out   out  registered A & B (held between ops)
//   CC_GateANDArbiter_OpCount_Out  out  completed-operation count (STATS_EN only)
// ---------------------------------------------------------------------------
module cc_gateand_arbiter #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
) (
  input  logic                        CC_GateANDArbiter_CLOCK_50,
  input  logic                        CC_GateANDArbiter_RESET_InLow,
  input  logic [(2**ID_W)-1:0]        CC_GateANDArbiter_Req_In,
  input  logic [(2**ID_W)*DATA_W-1:0] CC_GateANDArbiter_A_In,
  input  logic [(2**ID_W)*DATA_W-1:0] CC_GateANDArbiter_B_In,
  output logic [(2**ID_W)-1:0]        CC_GateANDArbiter_Grant_Out,
  output logic [(2**ID_W)-1:0]        CC_GateANDArbiter_Ack_Out,
  output logic                        CC_GateANDArbiter_Valid_Out,
  output logic [ID_W-1:0]             CC_GateANDArbiter_Id_Out,
  output logic [DATA_W-1:0]           CC_GateANDArbiter_Result_Out
`ifdef CC_GATEANDARBITER_STATS_EN
  ,
  output logic [15:0]                 CC_GateANDArbiter_OpCount_Out
`endif
);

  localparam int NUM_REQ = 2**ID_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     idx_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                valid_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   result_q;
`ifdef CC_GATEANDARBITER_STATS_EN
  logic [15:0]         opcount_q;
`endif

  // Unpack the flat operand buses so the granted slice can be picked by index.
  logic [DATA_W-1:0] a_slice [NUM_REQ];
  logic [DATA_W-1:0] b_slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_slice[gi] = CC_GateANDArbiter_A_In[gi*DATA_W +: DATA_W];
      assign b_slice[gi] = CC_GateANDArbiter_B_In[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: scan offsets from the highest down so that the
  // smallest offset from ptr_q (highest priority) is the last one written.
  // The ID_W-bit addition wraps modulo NUM_REQ by itself.
  logic                arb_hit;
  logic [ID_W-1:0]     arb_idx;
  logic [ID_W-1:0]     arb_cand;
  logic [NUM_REQ-1:0]  arb_onehot;

  always_comb begin
    arb_hit    = 1'b0;
    arb_idx    = '0;
    arb_cand   = '0;
    arb_onehot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_cand = ptr_q + ID_W'(k);
      if (CC_GateANDArbiter_Req_In[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
    arb_onehot[arb_idx] = arb_hit;
  end

  always_ff @(posedge CC_GateANDArbiter_CLOCK_50 or negedge CC_GateANDArbiter_RESET_InLow) begin
    if (!CC_GateANDArbiter_RESET_InLow) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
`ifdef CC_GATEANDARBITER_STATS_EN
      opcount_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // Operands are captured only here; later changes are ignored.
          if (arb_hit) begin
            a_q     <= a_slice[arb_idx];
            b_q     <= b_slice[arb_idx];
            idx_q   <= arb_idx;
            grant_q <= arb_onehot;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          result_q <= a_q & b_q;
          id_q     <= idx_q;
          valid_q  <= 1'b1;
          // The grant is already the one-hot of idx_q.
          ack_q    <= grant_q;
          state_q  <= S_DONE;
`ifdef CC_GATEANDARBITER_STATS_EN
          opcount_q <= opcount_q + 16'd1;
`endif
        end
        S_DONE: begin
          valid_q <= 1'b0;
          ack_q   <= '0;
          grant_q <= '0;
          // Served requester drops to lowest priority for the next round.
          ptr_q   <= idx_q + ID_W'(1);
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign CC_GateANDArbiter_Grant_Out  = grant_q;
  assign CC_GateANDArbiter_Ack_Out    = ack_q;
  assign CC_GateANDArbiter_Valid_Out  = valid_q;
  assign CC_GateANDArbiter_Id_Out     = id_q;
  assign CC_GateANDArbiter_Result_Out = result_q;
`ifdef CC_GATEANDARBITER_STATS_EN
  assign CC_GateANDArbiter_OpCount_Out = opcount_q;
`endif

endmodule

// File: tb/tb_cc_gateand_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cc_gateand_arbiter
//   Directed stimulus with hand-computed expectations. Stimulus pushes the
//   expected {id, result} of each transaction into a queue; an independent
//   monitor pops and compares whenever Valid is presented.
// ---------------------------------------------------------------------------
module tb_cc_gateand_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        valid;
  logic [1:0]  id;
  logic [7:0]  result;
`ifdef CC_GATEANDARBITER_STATS_EN
  logic [15:0] opcount;
`endif

  cc_gateand_arbiter #(.DATA_W(8), .ID_W(2)) dut (
    .CC_GateANDArbiter_CLOCK_50    (clk),
    .CC_GateANDArbiter_RESET_InLow (rst_n),
    .CC_GateANDArbiter_Req_In      (req),
    .CC_GateANDArbiter_A_In        (a_in),
    .CC_GateANDArbiter_B_In        (b_in),
    .CC_GateANDArbiter_Grant_Out   (grant),
    .CC_GateANDArbiter_Ack_Out     (ack),
    .CC_GateANDArbiter_Valid_Out   (valid),
    .CC_GateANDArbiter_Id_Out      (id),
    .CC_GateANDArbiter_Result_Out  (result)
`ifdef CC_GATEANDARBITER_STATS_EN
    ,
    .CC_GateANDArbiter_OpCount_Out (opcount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0] id;
    logic [7:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input logic [1:0] i, input logic [7:0] r);
    exp_t e;
    e.id  = i;
    e.res = r;
    sb_q.push_back(e);
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*8 +: 8] = a;
    b_in[i*8 +: 8] = b;
  endtask

  // Bounded wait for a specific requester's Ack; a timeout counts as a failure.
  task automatic wait_ack(input int who, input int budget, output int at_cyc);
    at_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ack[who] === 1'b1) begin
        at_cyc = cyc;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_ack%0d: no ack within %0d cycles, ack=0x%0h", who, budget, ack);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: id=%0d result=0x%0h, expected no transaction", id, result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("mon_id", 32'(id), 32'(e.id));
        chk("mon_result", 32'(result), 32'(e.res));
        chk("mon_ack", 32'(ack), 32'(onehot(e.id)));
        chk("mon_grant", 32'(grant), 32'(onehot(e.id)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int prev;
    logic saw;

    rst_n = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;

    // 1. Reset with random inputs, then idle.
    #2;
    rst_n = 1'b0;
    req   = 4'($urandom);
    a_in  = $urandom;
    b_in  = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_id", 32'(id), 0);
    chk("rst_result", 32'(result), 0);
    req  = '0;
    a_in = '0;
    b_in = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_grant_valid", {grant, 3'b0, valid}, 0);
    end

    // 2. Single request from requester 2.
    set_ops(2, 8'hF0, 8'h3C);
    req = 4'b0100;
    push(2'd2, 8'h30);
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_valid_early", 32'(valid), 0);
    wait_ack(2, 4, t);
    req = '0;
    @(negedge clk);
    chk("single_valid_1cyc", 32'(valid), 0);
    chk("single_ack_1cyc", 32'(ack), 0);
    chk("single_grant_clear", 32'(grant), 0);
    repeat (3) @(negedge clk);
    chk("single_result_hold", 32'(result), 32'h30);
    chk("single_id_hold", 32'(id), 2);

    // 3. Full contention from reset: order 0,1,2,3,0, three cycles apart.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'((i + 1) * 8'h11), 8'((i + 1) * 8'h11));
    req = 4'b1111;
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    push(2'd0, 8'h11);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack(i % 4, 8, t);
      if (i > 0) chk("rr_spacing", 32'(t - prev), 3);
      prev = t;
    end
    req = '0;

    // 4. Pointer: serve 1 (ptr -> 2), then 1001 serves 3 then wraps to 0.
    repeat (3) @(negedge clk);
    set_ops(1, 8'hAA, 8'h0F);
    req = 4'b0010;
    push(2'd1, 8'h0A);
    wait_ack(1, 6, t);
    set_ops(3, 8'hC3, 8'h5A);
    set_ops(0, 8'h81, 8'hFF);
    req = 4'b1001;
    push(2'd3, 8'h42);
    push(2'd0, 8'h81);
    wait_ack(3, 8, t);
    req = 4'b0001;
    wait_ack(0, 8, t);
    req = '0;

    // 5. Reset during BUSY aborts; requester 2 is served again afterwards.
    repeat (3) @(negedge clk);
    set_ops(2, 8'h5A, 8'h3C);
    req = 4'b0100;
    @(negedge clk);
    chk("abort_grant_before", 32'(grant), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("abort_grant_clear", 32'(grant), 0);
    chk("abort_result_clear", 32'(result), 0);
    saw = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      saw = saw | valid | (|ack);
    end
    chk("abort_no_ack", 32'(saw), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(2'd2, 8'h18);
    wait_ack(2, 6, t);
    req = '0;

`ifdef CC_GATEANDARBITER_STATS_EN
    // 6. Operation counter and its wrap.
    do_reset();
    set_ops(0, 8'h81, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      req = 4'b0001;
      push(2'd0, 8'h81);
      wait_ack(0, 6, t);
      req = '0;
      repeat (2) @(negedge clk);
    end
    chk("opcount_5", 32'(opcount), 5);
    force dut.opcount_q = 16'hFFFF;
    @(negedge clk);
    release dut.opcount_q;
    req = 4'b0001;
    push(2'd0, 8'h81);
    wait_ack(0, 6, t);
    req = '0;
    repeat (2) @(negedge clk);
    chk("opcount_wrap", 32'(opcount), 0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
